// File: rtl/router_source_fifo.sv
// Terminal-side source FIFO feeding one router port.
// First-word fall-through: the head packet is presented as soon as it is written,
// and the router consumes it with a one-cycle pop while pndng_i_in is high.
// Overflowing pushes are counted (saturating), and pops while empty set a sticky flag.
module router_source_fifo #(
    parameter int unsigned DATA_W = 40,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DATA_W-1:0]          data_out_i_in,
    output logic                       pndng_i_in,
    input  logic                       pop,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       underflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW:0]     count_q;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic              underflow_q;

    logic              do_pop;
    logic              do_push;

    // Outputs are decoded purely from registered state; push/pop never reach them.
    always_comb begin
        pndng_i_in    = (count_q != '0);
        full          = (count_q == FullCount);
        count         = count_q;
        drop_cnt      = drop_cnt_q;
        underflow     = underflow_q;
        data_out_i_in = pndng_i_in ? mem[rd_ptr_q] : '0;
    end

    // A push into a full FIFO is still accepted when the same cycle frees the head slot.
    always_comb begin
        do_pop  = pop & pndng_i_in;
        do_push = push & (~full | do_pop);
    end

    // Storage write; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Pointers, occupancy and error bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            drop_cnt_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (push && !do_push && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
            if (pop && !pndng_i_in) begin
                underflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_router_source_fifo.sv
// Self-checking bench for router_source_fifo: directed vector table, hand-written
// corner sequences and a randomized run, all checked against a queue-based model.
module tb_router_source_fifo;

    localparam int DW    = 40;
    localparam int DEPTH = 16;
    localparam int CW    = 4;   // narrow drop counter so saturation is reachable

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] din = '0;
    logic          full;
    logic [4:0]    count;
    logic [DW-1:0] data_out_i_in;
    logic          pndng_i_in;
    logic [CW-1:0] drop_cnt;
    logic          underflow;

    always #5 clk = ~clk;

    router_source_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .din          (din),
        .full         (full),
        .count        (count),
        .data_out_i_in(data_out_i_in),
        .pndng_i_in   (pndng_i_in),
        .pop          (pop),
        .drop_cnt     (drop_cnt),
        .underflow    (underflow)
    );

    // Reference model: a plain queue plus the two error records.
    logic [DW-1:0] mq[$];
    int            m_drop;
    bit            m_uf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit            p;
        bit            po;
        logic [DW-1:0] d;
        int unsigned   cnt;
        bit            pend;
        logic [DW-1:0] data;
        bit            uf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [DW-1:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        check("count", 64'(count), 64'(mq.size()));
        check("pndng", 64'(pndng_i_in), 64'(mq.size() != 0));
        check("full", 64'(full), 64'(mq.size() == DEPTH));
        check("head", 64'(data_out_i_in), 64'(head));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        check("underflow", 64'(underflow), 64'(m_uf));
    endtask

    // One clock: apply inputs, advance the model by the FIFO's rules, then compare.
    task automatic step(input bit p, input bit po, input logic [DW-1:0] d);
        bit eff_pop;
        bit eff_push;
        push = p;
        pop  = po;
        din  = d;
        eff_pop  = po && (mq.size() > 0);
        eff_push = p && ((mq.size() < DEPTH) || eff_pop);
        if (po && mq.size() == 0) m_uf = 1'b1;
        if (p && !eff_push && m_drop < (2 ** CW) - 1) m_drop++;
        @(posedge clk);
        if (eff_pop) void'(mq.pop_front());
        if (eff_push) mq.push_back(d);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        check_model();
    endtask

    // Reset with push/pop also asserted to show reset wins.
    task automatic do_reset();
        rst  = 1'b1;
        push = 1'b1;
        pop  = 1'b1;
        din  = {8'hFF, 32'($urandom)};
        @(posedge clk);
        #1;
        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        mq.delete();
        m_drop = 0;
        m_uf   = 1'b0;
        check_model();
    endtask

    initial begin
        vecs[0]  = '{0, 0, 40'h0,           0, 0, 40'h0,           0};
        vecs[1]  = '{0, 1, 40'h0,           0, 0, 40'h0,           1};
        vecs[2]  = '{1, 0, 40'hAA00000001,  1, 1, 40'hAA00000001,  1};
        vecs[3]  = '{0, 0, 40'h0,           1, 1, 40'hAA00000001,  1};
        vecs[4]  = '{0, 1, 40'h0,           0, 0, 40'h0,           1};
        vecs[5]  = '{1, 0, 40'h111,         1, 1, 40'h111,         1};
        vecs[6]  = '{1, 0, 40'h222,         2, 1, 40'h111,         1};
        vecs[7]  = '{1, 1, 40'h333,         2, 1, 40'h222,         1};
        vecs[8]  = '{0, 1, 40'h0,           1, 1, 40'h333,         1};
        vecs[9]  = '{1, 1, 40'h444,         1, 1, 40'h444,         1};
        vecs[10] = '{0, 1, 40'h0,           0, 0, 40'h0,           1};
        vecs[11] = '{1, 1, 40'h555,         1, 1, 40'h555,         1};

        m_drop = 0;
        m_uf   = 1'b0;
        do_reset();

        // Directed table: reset/idle, underflow, first-word fall-through, push+pop corners.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].p, vecs[i].po, vecs[i].d);
            check($sformatf("vec%0d count", i), 64'(count), 64'(vecs[i].cnt));
            check($sformatf("vec%0d pndng", i), 64'(pndng_i_in), 64'(vecs[i].pend));
            check($sformatf("vec%0d data", i), 64'(data_out_i_in), 64'(vecs[i].data));
            check($sformatf("vec%0d underflow", i), 64'(underflow), 64'(vecs[i].uf));
        end

        // Fill, overflow by 3, then push+pop while full across pointer wrap, then drain.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 0, 40'hC000000000 + 40'(i));
        for (int i = 0; i < 3; i++) step(1, 0, 40'hDEAD);
        check("fill full", 64'(full), 64'd1);
        check("fill count", 64'(count), 64'd16);
        check("fill drop", 64'(drop_cnt), 64'd3);
        check("fill head", 64'(data_out_i_in), 64'hC000000000);
        for (int i = 0; i < 20; i++) step(1, 1, 40'hE000000000 + 40'(i));
        check("swap count", 64'(count), 64'd16);
        check("swap drop", 64'(drop_cnt), 64'd3);
        check("swap head", 64'(data_out_i_in), 64'hE000000004);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain%0d", i), 64'(data_out_i_in), 64'hE000000004 + 64'(i));
            step(0, 1, '0);
        end
        check("drained pndng", 64'(pndng_i_in), 64'd0);

        // Drop counter saturates rather than wrapping.
        for (int i = 0; i < DEPTH + 20; i++) step(1, 0, 40'hF0 + 40'(i));
        check("drop saturate", 64'(drop_cnt), 64'hF);

        // Streaming from one entry: push and pop every cycle.
        do_reset();
        step(1, 0, 40'h5000000000);
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 40'h5000000001 + 40'(i));
            check($sformatf("stream%0d count", i), 64'(count), 64'd1);
        end

        // Reset mid-stream at occupancy 7 discards everything.
        for (int i = 0; i < 6; i++) step(1, 0, 40'h7700 + 40'(i));
        check("pre-reset count", 64'(count), 64'd7);
        do_reset();
        check("post-reset count", 64'(count), 64'd0);
        check("post-reset pndng", 64'(pndng_i_in), 64'd0);
        step(1, 0, 40'h12345);
        check("post-reset head", 64'(data_out_i_in), 64'h12345);

        // Randomized traffic with shifting push/pop bias and rare resets.
        for (int i = 0; i < 3000; i++) begin
            int pb;
            pb = (i / 300) % 2 == 0 ? 70 : 35;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < pb, $urandom_range(0, 99) < 50,
                     {8'(i), 32'($urandom)});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
